alu_wide_add_sequencer: RTL and testbench

- Multi-cycle initiator that drives the 32-bit ArithmeticLogicUnit to perform one 64-bit addition.
- Issues the low word with FunSel 5'b10100 (A+B), then the high word with FunSel 5'b10101 (A+B+C), and collects ALUOut and the clocked FlagsOut {Z,C,N,O}.
- Sits between the control unit and the ALU instance; the ALU's flag register is the carry link between the two words.

---
 rtl/alu_wide_add_sequencer.sv | 85 ++++++++
 tb/tb_alu_wide_add_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_wide_add_sequencer.sv
// alu_wide_add_sequencer: chains two 32-bit ALU adds (ADD then ADC) into one 64-bit add.
// Optional ALU_WIDE_ADD_OPCOUNT_EN adds a 16-bit completed-operation counter with ClrCount.
module alu_wide_add_sequencer #(
  parameter int W = 32,
  parameter logic [4:0] FS_ADD = 5'b10100,
  parameter logic [4:0] FS_ADC = 5'b10101
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [2*W-1:0] OpA,
  input  logic [2*W-1:0] OpB,
`ifdef ALU_WIDE_ADD_OPCOUNT_EN
  input  logic           ClrCount,
  output logic [15:0]    OpCount,
`endif
  output logic           Ready,
  output logic           Done,
  output logic [2*W-1:0] Result,
  output logic [3:0]     ResFlags,
  output logic [W-1:0]   ALU_A,
  output logic [W-1:0]   ALU_B,
  output logic [4:0]     ALU_FunSel,
  output logic           ALU_WF,
  input  logic [W-1:0]   ALUOut,
  input  logic [3:0]     FlagsOut
);
  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;
  state_t state_q, state_d;
  logic [2*W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic lo_zero_q, lo_zero_d;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      lo_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      lo_zero_q <= lo_zero_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (Start ? LO : IDLE) :
              state_q == LO   ? HI :
              state_q == HI   ? FIN : IDLE;
  end
  // The ALU only sees the high word's zero flag, so the low word's zero is kept to build Z.
  always_comb begin
    a_d       = (state_q == IDLE && Start) ? OpA : a_q;
    b_d       = (state_q == IDLE && Start) ? OpB : b_q;
    result_d  = state_q == LO ? {result_q[2*W-1:W], ALUOut} :
                state_q == HI ? {ALUOut, result_q[W-1:0]} : result_q;
    lo_zero_d = state_q == LO ? (ALUOut == '0) : lo_zero_q;
    flags_d   = state_q == FIN ? {FlagsOut[3] & lo_zero_q, FlagsOut[2:0]} : flags_q;
  end
  always_comb begin
    Ready      = state_q == IDLE;
    Done       = state_q == FIN;
    ALU_A      = state_q == LO ? a_q[W-1:0] : state_q == HI ? a_q[2*W-1:W] : '0;
    ALU_B      = state_q == LO ? b_q[W-1:0] : state_q == HI ? b_q[2*W-1:W] : '0;
    ALU_FunSel = state_q == HI ? FS_ADC : FS_ADD;
    ALU_WF     = state_q == LO || state_q == HI;
    Result     = result_q;
    ResFlags   = flags_q;
  end
`ifdef ALU_WIDE_ADD_OPCOUNT_EN
  logic [15:0] count_q, count_d;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) count_q <= '0;
    else        count_q <= count_d;
  end
  always_comb begin
    count_d = ClrCount ? 16'd0 : state_q == FIN ? count_q + 16'd1 : count_q;
    OpCount = count_q;
  end
`endif
endmodule

// File: tb/tb_alu_wide_add_sequencer.sv
// tb_alu_wide_add_sequencer: drives the sequencer against a behavioural 32-bit ALU and
// scores each 64-bit sum against a direct 65-bit reference.
module tb_alu_wide_add_sequencer;
  localparam int W = 32;
  logic Clock = 0, Reset = 0, Start = 0;
  logic [63:0] OpA = 0, OpB = 0, Result;
  logic Ready, Done, ALU_WF;
  logic [3:0] ResFlags, FlagsOut;
  logic [W-1:0] ALU_A, ALU_B, ALUOut;
  logic [4:0] ALU_FunSel;
`ifdef ALU_WIDE_ADD_OPCOUNT_EN
  logic ClrCount = 0;
  logic [15:0] OpCount;
`endif
  alu_wide_add_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
`ifdef ALU_WIDE_ADD_OPCOUNT_EN
    .ClrCount(ClrCount), .OpCount(OpCount),
`endif
    .Ready(Ready), .Done(Done), .Result(Result), .ResFlags(ResFlags),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ALUOut(ALUOut), .FlagsOut(FlagsOut));
  always #5 Clock = ~Clock;
  logic [3:0] alu_flags = 0;
  logic [W:0] alu_sum;
  always_comb alu_sum = {1'b0, ALU_A} + {1'b0, ALU_B} + {{W{1'b0}}, ALU_FunSel == 5'b10101 ? alu_flags[2] : 1'b0};
  assign ALUOut = alu_sum[W-1:0];
  assign FlagsOut = alu_flags;
  always @(posedge Clock)
    if (ALU_WF)
      alu_flags <= {alu_sum[W-1:0] == '0, alu_sum[W], alu_sum[W-1],
                    (ALU_A[W-1] == ALU_B[W-1]) && (alu_sum[W-1] != ALU_A[W-1])};
  typedef struct {logic [63:0] res; logic [3:0] flg;} exp_t;
  exp_t q[$];
  int done_cyc[$];
  int cyc = 0, vectors = 0, errors = 0;
  logic flag_pend = 0;
  logic [3:0] pend_flags;
  always @(posedge Clock) cyc <= cyc + 1;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(logic [63:0] a, logic [63:0] b);
    logic [64:0] s;
    exp_t e;
    s = {1'b0, a} + {1'b0, b};
    e.res = s[63:0];
    e.flg = {s[63:0] == 64'd0, s[64], s[63], (a[63] == b[63]) && (s[63] != a[63])};
    return e;
  endfunction
  always @(negedge Clock) begin
    if (!Reset) flag_pend = 0;
    else begin
      if (flag_pend) begin
        check("flags", {60'd0, ResFlags}, {60'd0, pend_flags});
        flag_pend = 0;
      end
      if (Done) begin
        if (q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("result", Result, e.res);
          pend_flags = e.flg;
          flag_pend = 1;
          done_cyc.push_back(cyc);
        end
      end
      if (Start && Ready) q.push_back(model(OpA, OpB));
    end
  end
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || flag_pend) && n < 30) begin
      @(posedge Clock);
      n++;
    end
    if (n >= 30) check("drain_timeout", 64'd1, 64'd0);
    @(posedge Clock);
  endtask
  task automatic op(logic [63:0] a, logic [63:0] b);
    @(posedge Clock); #1;
    OpA = a; OpB = b; Start = 1;
    @(posedge Clock); #1;
    Start = 0;
  endtask
  initial begin
    #12;
    check("rst_ready", {63'd0, Ready}, 64'd1);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_result", Result, 64'd0);
    check("rst_funsel", {59'd0, ALU_FunSel}, 64'h14);
    check("rst_wf", {63'd0, ALU_WF}, 64'd0);
    Reset = 1;
    op(64'h00000001_FFFFFFFF, 64'h00000000_00000001);
    drain();
    check("lit_res1", Result, 64'h00000002_00000000);
    check("lit_flg1", {60'd0, ResFlags}, 64'h0);
    op(64'hFFFFFFFF_FFFFFFFF, 64'h1);
    drain();
    check("lit_flg2", {60'd0, ResFlags}, 64'hC);
    op(64'h00000000_FFFFFFFF, 64'hFFFFFFFF_00000002);
    drain();
    check("lit_res3", Result, 64'h00000000_00000001);
    check("lit_flg3", {60'd0, ResFlags}, 64'h4);
    op(64'h7FFFFFFF_FFFFFFFF, 64'h1);
    drain();
    check("lit_flg4", {60'd0, ResFlags}, 64'h3);
    for (int i = 0; i < 6; i++) begin
      op({$urandom, $urandom}, {$urandom, $urandom});
      drain();
    end
    op(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321);
    @(posedge Clock); #1;
    OpA = 64'hDEAD; OpB = 64'hBEEF; Start = 1;
    @(posedge Clock); #1;
    Start = 0;
    drain();
    check("ign_res", Result, 64'h22222222_22222211);
    op(64'h5, 64'h6);
    @(posedge Clock); #3;
    Reset = 0;
    #1;
    check("abort_ready", {63'd0, Ready}, 64'd1);
    check("abort_done", {63'd0, Done}, 64'd0);
    check("abort_result", Result, 64'd0);
    check("abort_flags", {60'd0, ResFlags}, 64'd0);
    check("abort_wf", {63'd0, ALU_WF}, 64'd0);
    q.delete();
    @(posedge Clock); #1;
    Reset = 1;
    op(64'h00000003_00000004, 64'h00000005_00000006);
    drain();
    check("post_abort_res", Result, 64'h00000008_0000000A);
    done_cyc.delete();
    @(posedge Clock); #1;
    OpA = 64'hFFFFFFFF_00000001; OpB = 64'h00000001_FFFFFFFF; Start = 1;
    for (int n = 0; n < 40 && done_cyc.size() < 3; n++) begin
      @(negedge Clock); #1;
    end
    Start = 0;
    if (done_cyc.size() < 3) check("b2b_timeout", {32'd0, done_cyc.size()}, 64'd3);
    else begin
      check("b2b_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'd4);
      check("b2b_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'd4);
    end
    drain();
`ifdef ALU_WIDE_ADD_OPCOUNT_EN
    @(posedge Clock); #1;
    ClrCount = 1;
    @(posedge Clock); #1;
    ClrCount = 0;
    check("cnt_clr", {48'd0, OpCount}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      op(64'(i), 64'd1);
      drain();
    end
    check("cnt_3", {48'd0, OpCount}, 64'd3);
    op(64'd1, 64'd1);
    for (int n = 0; n < 10 && !Done; n++) @(negedge Clock);
    ClrCount = 1;
    @(posedge Clock); #1;
    ClrCount = 0;
    check("cnt_clr_done", {48'd0, OpCount}, 64'd0);
    drain();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
